rgb_duty_sched: RTL and testbench
=================================

RGB_DUTY_SCHED -- requirements
Module: rgb_duty_sched

Interface
REQ-001 SHALL have parameter SIZE, default 13: width of the duty word and of each target.
REQ-002 SHALL have parameter STEP, default 16: duty increment per fade tick; used only with RGB_FADE_EN.
REQ-003 SHALL have parameter TICK_DIV, default 1000: sys_clk cycles per fade tick (at least 2); used only with RGB_FADE_EN.
REQ-004 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 req  in  3  per-channel update request, level-sampled each edge; bit0=R, bit1=G, bit2=B.
REQ-007 tgt_r, tgt_g, tgt_b  in  SIZE each  requested duty per channel; valid while the matching req bit is high.
REQ-008 ack  out  3  one-cycle pulse on the edge after the matching req is sampled.
REQ-009 duty  out  SIZE  shared duty bus to the three PWM cores.
REQ-010 load_r, load_g, load_b  out  1 each  one-cycle load strobe to the matching PWM core; at most one high per cycle.
REQ-011 busy  out  1  high when any channel is pending or the FSM is not in IDLE.

Function
REQ-012 On req[i] sampled high, the block SHALL capture tgt_i into target register T[i], set pending[i] and pulse ack[i] next cycle.
REQ-013 A repeat req[i] while pending[i] is set SHALL overwrite T[i] (latest wins) and SHALL be acked; no request is lost or queued twice.
REQ-014 FSM states: IDLE, GRANT, LOAD.
- IDLE->GRANT when any pending bit is set.
- GRANT->LOAD unconditionally.
- LOAD->GRANT if any pending bit is set, else LOAD->IDLE.
REQ-015 In GRANT the block SHALL select channel g by round-robin and register duty for channel g; without fade it SHALL also clear pending[g].
- Search starts one position after the last grant; the pointer is R after reset, searching R, G, B.
REQ-016 In LOAD the block SHALL assert load_<g> for exactly one cycle.
- duty SHALL equal the value registered in GRANT during that cycle and SHALL hold it until the next GRANT.
REQ-017 Latency: req high at edge N -> pending at N -> GRANT at N+1 -> load strobe high in the cycle after edge N+2.
REQ-018 Simultaneous req[g] and clearing of pending[g] in GRANT: the set SHALL win, the new T[g] is kept and the channel is served again later.
REQ-019 All three requests in one cycle SHALL produce loads in round-robin order, two cycles apart, with no idle gap.
REQ-020 duty and the load strobes SHALL be registered outputs.

Reset
REQ-021 rst low SHALL immediately clear all of the following: duty=0, load_*=0, ack=0, busy=0, pending=0, T[*]=0, state=IDLE, RR pointer=R, fade tick counter=0, C[*]=0.
REQ-022 Reset mid-LOAD SHALL drop the strobe at once; the request SHALL NOT be replayed after reset release.

Configuration
REQ-023 Macro RGB_FADE_EN.
- Defined: each channel keeps a current value C[i] and grants SHALL occur only in the IDLE or LOAD cycle coinciding with the fade tick (every TICK_DIV cycles).
- Defined: GRANT SHALL set C[g] to C[g]+/-STEP toward T[g], clamped so it never overshoots, and duty SHALL equal the new C[g].
- Defined: pending[g] SHALL clear only when C[g]==T[g] after the step.
- Defined: arithmetic SHALL be unsigned SIZE+1 bits before clamping; no wrap at 0 or 2^SIZE-1.
- Undefined: duty SHALL equal T[g] directly, there is no tick gating, and C and the tick counter SHALL not exist.

Structure
REQ-024 Package rgb_pwm_pkg SHALL hold the SIZE default, channel index constants CH_R=0, CH_G=1, CH_B=2, and the FSM state typedef.
REQ-025 Round-robin selection SHALL be the sub-module rr_arb3, with inputs pending[2:0], pointer and advance, and outputs grant index and valid.

Verification
REQ-026 Bench SHALL cover the following directed scenarios:
- Reset release, then req=001 with tgt_r=0x0800 for 1 cycle -> ack=001 next cycle; load_r high exactly one cycle, 3 cycles after req; duty=0x0800; busy low afterwards.
- req=111 in one cycle with R=0x100, G=0x200, B=0x300 -> loads R, G, B at 2-cycle spacing with matching duty values; only one load high at a time.
- req[1] high with 0x010 then next cycle 0x020 before grant -> a single load_g with duty=0x020.
- rst low asserted during LOAD -> all outputs 0 in the same cycle; no load after release.
- RGB_FADE_EN, TICK_DIV=4, STEP=16, tgt_b=40 from C=0 -> duty 16, 32, 40 at consecutive ticks, then pending clear.
- RGB_FADE_EN, tgt_b=0 from C=40 -> duty 24, 8, 0; no underflow.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_pwm_pkg
// Description : Shared constants, channel indices and FSM state type for the
//               RGB duty scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_pwm_pkg;

    localparam int SIZE_DEF = 13;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Channel index arithmetic on the three-entry R, G, B ring.
    function automatic logic [1:0] ch_add(input logic [1:0] ch, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, ch} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb3
// Description : Three-way round-robin picker; search starts at pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb3
    import rgb_pwm_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] pointer,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] w_idx;

    always_comb begin
        grant = CH_R;
        valid = 1'b0;
        w_idx = CH_R;
        // Walk the ring backwards so the position nearest the pointer wins.
        for (int k = 2; k >= 0; k--) begin
            w_idx = ch_add(pointer, 2'(k));
            if (pending[w_idx]) begin
                grant = w_idx;
                valid = advance;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_duty_sched.sv
`default_nettype none
// ============================================================================
// Module      : rgb_duty_sched
// Description : Serialises per-channel duty updates onto one shared duty bus
//               with per-core load strobes. Optional macro RGB_FADE_EN adds
//               tick-gated stepping toward each target.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_duty_sched
    import rgb_pwm_pkg::*;
#(
    parameter int SIZE     = SIZE_DEF,
    parameter int STEP     = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [SIZE-1:0] tgt_r,
    input  logic [SIZE-1:0] tgt_g,
    input  logic [SIZE-1:0] tgt_b,
    output logic [2:0]      ack,
    output logic [SIZE-1:0] duty,
    output logic            load_r,
    output logic            load_g,
    output logic            load_b,
    output logic            busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SIZE-1:0] r_tgt [3];
    logic [SIZE-1:0] w_tgt_in [3];
    logic [2:0]      r_pending;
    logic [2:0]      r_ack;
    logic [2:0]      r_load;
    logic [2:0]      w_clr;
    logic [1:0]      r_ptr;
    logic [1:0]      w_grant;
    logic            w_valid;
    logic            w_go;
    logic            w_tick;
    logic            w_done;
    logic [SIZE-1:0] r_duty;
    logic [SIZE-1:0] w_tgt_sel;
    logic [SIZE-1:0] w_new_duty;

    assign w_tgt_in[0] = tgt_r;
    assign w_tgt_in[1] = tgt_g;
    assign w_tgt_in[2] = tgt_b;

    rr_arb3 u_arb (
        .pending (r_pending),
        .pointer (r_ptr),
        .advance (r_state == ST_GRANT),
        .grant   (w_grant),
        .valid   (w_valid)
    );

    always_comb begin
        w_tgt_sel = r_tgt[0];
        case (w_grant)
            CH_G:    w_tgt_sel = r_tgt[1];
            CH_B:    w_tgt_sel = r_tgt[2];
            default: w_tgt_sel = r_tgt[0];
        endcase
    end

`ifdef RGB_FADE_EN
    localparam int              c_cnt_w     = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(TICK_DIV - 1);
    localparam logic [SIZE:0]   c_step      = (SIZE+1)'(STEP);

    logic [c_cnt_w-1:0] r_tick_cnt;
    logic [SIZE-1:0]    r_cur [3];
    logic [SIZE-1:0]    w_cur_sel;
    logic [SIZE:0]      w_up;
    logic [SIZE:0]      w_dn;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_comb begin
        w_cur_sel = r_cur[0];
        case (w_grant)
            CH_G:    w_cur_sel = r_cur[1];
            CH_B:    w_cur_sel = r_cur[2];
            default: w_cur_sel = r_cur[0];
        endcase
    end

    // One extra bit catches overflow above 2^SIZE-1 and borrow below 0.
    always_comb begin
        w_up       = {1'b0, w_cur_sel} + c_step;
        w_dn       = {1'b0, w_cur_sel} - c_step;
        w_new_duty = w_tgt_sel;
        if (w_cur_sel < w_tgt_sel) begin
            if (w_up < {1'b0, w_tgt_sel}) w_new_duty = w_up[SIZE-1:0];
        end else if (!w_dn[SIZE] && (w_dn[SIZE-1:0] > w_tgt_sel)) begin
            w_new_duty = w_dn[SIZE-1:0];
        end
    end

    assign w_done = (w_new_duty == w_tgt_sel);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            for (int i = 0; i < 3; i++) r_cur[i] <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_cnt_w'(1);
            for (int i = 0; i < 3; i++) begin
                if (w_valid && (w_grant == 2'(i))) r_cur[i] <= w_new_duty;
            end
        end
    end
`else
    assign w_tick     = 1'b1;
    assign w_new_duty = w_tgt_sel;
    assign w_done     = 1'b1;
`endif

    assign w_go  = (|r_pending) & w_tick;
    assign w_clr = (w_valid && w_done) ? (3'b001 << w_grant) : 3'b000;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_state_nxt = ST_GRANT;
            ST_GRANT: w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = w_go ? ST_GRANT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // A request arriving on the edge that clears its pending bit wins.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_ack     <= '0;
            r_load    <= '0;
            r_duty    <= '0;
            r_ptr     <= CH_R;
            for (int i = 0; i < 3; i++) r_tgt[i] <= '0;
        end else begin
            r_ack     <= req;
            r_pending <= (r_pending & ~w_clr) | req;
            for (int i = 0; i < 3; i++) begin
                if (req[i]) r_tgt[i] <= w_tgt_in[i];
            end
            r_load <= '0;
            if (w_valid) begin
                r_load <= 3'b001 << w_grant;
                r_duty <= w_new_duty;
                r_ptr  <= ch_add(w_grant, 2'd1);
            end
        end
    end

    assign ack    = r_ack;
    assign duty   = r_duty;
    assign load_r = r_load[CH_R];
    assign load_g = r_load[CH_G];
    assign load_b = r_load[CH_B];
    assign busy   = (|r_pending) | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rgb_duty_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_duty_sched
// Description : Directed bench for rgb_duty_sched with a cycle-level
//               reference model and hand-computed scenario expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_duty_sched;

    localparam int SIZE     = 13;
    localparam int STEP     = 16;
    localparam int TICK_DIV = 4;
`ifdef RGB_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b1;
    logic [2:0]      req     = '0;
    logic [SIZE-1:0] tgt_r   = '0;
    logic [SIZE-1:0] tgt_g   = '0;
    logic [SIZE-1:0] tgt_b   = '0;
    logic [2:0]      ack;
    logic [SIZE-1:0] duty;
    logic            load_r;
    logic            load_g;
    logic            load_b;
    logic            busy;

    rgb_duty_sched #(.SIZE(SIZE), .STEP(STEP), .TICK_DIV(TICK_DIV)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .req     (req),
        .tgt_r   (tgt_r),
        .tgt_g   (tgt_g),
        .tgt_b   (tgt_b),
        .ack     (ack),
        .duty    (duty),
        .load_r  (load_r),
        .load_g  (load_g),
        .load_b  (load_b),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lds();
        return {load_b, load_g, load_r};
    endfunction

    // Reference model: a grant edge is always preceded by one decision edge
    // (idle or post-load) on which some channel was pending.
    int              m_t [3];
    int              m_c [3];
    bit              m_pend [3];
    int              m_ptr;
    int              m_grant_at;
    int              m_edge;
    logic [2:0]      exp_ack;
    logic [2:0]      exp_load;
    logic [SIZE-1:0] exp_duty;
    logic            exp_busy;
    bit              cmp_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_t[i] = 0; m_c[i] = 0; m_pend[i] = 1'b0;
        end
        m_ptr = 0; m_grant_at = -1; m_edge = 0;
        exp_ack = '0; exp_load = '0; exp_duty = '0; exp_busy = 1'b0;
    endtask

    task automatic model_update();
        int g;
        bit any;
        g   = -1;
        any = m_pend[0] | m_pend[1] | m_pend[2];
        exp_load = '0;
        if (m_grant_at == m_edge) begin
            for (int k = 0; k < 3; k++)
                if (g < 0 && m_pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            if (g >= 0) begin
                if (FADE) begin
                    if (m_c[g] < m_t[g])
                        m_c[g] = (m_c[g] + STEP > m_t[g]) ? m_t[g] : m_c[g] + STEP;
                    else
                        m_c[g] = (m_c[g] - m_t[g] <= STEP) ? m_t[g] : m_c[g] - STEP;
                    exp_duty = SIZE'(m_c[g]);
                    if (m_c[g] == m_t[g]) m_pend[g] = 1'b0;
                end else begin
                    exp_duty  = SIZE'(m_t[g]);
                    m_pend[g] = 1'b0;
                end
                exp_load[g] = 1'b1;
                m_ptr = (g + 1) % 3;
            end
            m_grant_at = -1;
        end else if (any && (!FADE || (m_edge % TICK_DIV == TICK_DIV - 1))) begin
            m_grant_at = m_edge + 1;
        end
        if (req[0]) begin m_pend[0] = 1'b1; m_t[0] = int'(tgt_r); end
        if (req[1]) begin m_pend[1] = 1'b1; m_t[1] = int'(tgt_g); end
        if (req[2]) begin m_pend[2] = 1'b1; m_t[2] = int'(tgt_b); end
        exp_ack  = req;
        exp_busy = m_pend[0] | m_pend[1] | m_pend[2] | (m_grant_at >= 0) | (exp_load != 0);
        m_edge++;
    endtask

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("cyc_ack",  32'(ack),   32'(exp_ack));
            chk("cyc_load", 32'(lds()), 32'(exp_load));
            chk("cyc_duty", 32'(duty),  32'(exp_duty));
            chk("cyc_busy", 32'(busy),  32'(exp_busy));
        end
    end

    typedef struct {
        int         cyc;
        logic [2:0] ld;
        int         dv;
    } ld_t;

    ld_t log_q[$];
    int  cyc;

    task automatic step(input logic [2:0] r, input int vr, input int vg, input int vb);
        req   = r;
        tgt_r = SIZE'(vr);
        tgt_g = SIZE'(vg);
        tgt_b = SIZE'(vb);
        @(posedge sys_clk);
        model_update();
        @(negedge sys_clk);
        cyc++;
        if (lds() != 3'b000) log_q.push_back('{cyc, lds(), int'(duty)});
    endtask

    task automatic assert_reset();
        #2;
        req = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b1;
        cyc = 0;
        log_q.delete();
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_duty", 32'(duty),  32'd0);
        chk("rst_load", 32'(lds()), 32'd0);
        chk("rst_ack",  32'(ack),   32'd0);
        chk("rst_busy", 32'(busy),  32'd0);
        rst    = 1'b1;
        cmp_en = 1'b1;
        cyc    = 0;

`ifndef RGB_FADE_EN
        // Single red request: ack next cycle, strobe two cycles later.
        step(3'b001, 'h800, 0, 0);
        chk("s1_ack", 32'(ack), 32'd1);
        chk("s1_no_load_c1", 32'(lds()), 32'd0);
        step(3'b000, 0, 0, 0);
        chk("s1_no_load_c2", 32'(lds()), 32'd0);
        step(3'b000, 0, 0, 0);
        chk("s1_load_r", 32'(lds()), 32'd1);
        chk("s1_duty", 32'(duty), 32'h800);
        step(3'b000, 0, 0, 0);
        chk("s1_load_once", 32'(lds()), 32'd0);
        chk("s1_busy_low", 32'(busy), 32'd0);

        // All three at once: R, G, B at two-cycle spacing.
        do_reset();
        step(3'b111, 'h100, 'h200, 'h300);
        repeat (8) step(3'b000, 0, 0, 0);
        chk("s2_nloads", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("s2_chan", 32'(log_q[k].ld), 32'(3'b001 << k));
                chk("s2_duty", 32'(log_q[k].dv), 32'((k + 1) * 'h100));
                chk("s2_cyc",  32'(log_q[k].cyc), 32'(3 + 2 * k));
            end
        end

        // Overwrite before grant: latest green target is the only load.
        do_reset();
        step(3'b010, 0, 'h010, 0);
        step(3'b010, 0, 'h020, 0);
        repeat (6) step(3'b000, 0, 0, 0);
        chk("s3_nloads", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            chk("s3_chan", 32'(log_q[0].ld), 32'd2);
            chk("s3_duty", 32'(log_q[0].dv), 32'h020);
        end

        // Reset in the middle of the load cycle.
        do_reset();
        step(3'b001, 'h555, 0, 0);
        step(3'b000, 0, 0, 0);
        step(3'b000, 0, 0, 0);
        chk("s4_pre_load", 32'(lds()), 32'd1);
        assert_reset();
        #1;
        chk("s4_load_drop", 32'(lds()), 32'd0);
        chk("s4_duty_zero", 32'(duty),  32'd0);
        chk("s4_ack_zero",  32'(ack),   32'd0);
        chk("s4_busy_zero", 32'(busy),  32'd0);
        release_reset();
        repeat (6) step(3'b000, 0, 0, 0);
        chk("s4_no_replay", 32'(log_q.size()), 32'd0);

        // New request on the grant edge of the same channel is served again.
        do_reset();
        step(3'b001, 'h111, 0, 0);
        step(3'b000, 0, 0, 0);
        step(3'b001, 'h222, 0, 0);
        repeat (6) step(3'b000, 0, 0, 0);
        chk("s5_nloads", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("s5_duty0", 32'(log_q[0].dv), 32'h111);
            chk("s5_duty1", 32'(log_q[1].dv), 32'h222);
            chk("s5_gap",   32'(log_q[1].cyc - log_q[0].cyc), 32'd2);
        end
`else
        // Fade blue up from 0 to 40, then back down to 0.
        step(3'b100, 0, 0, 40);
        repeat (20) step(3'b000, 0, 0, 0);
        chk("f1_nloads", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("f1_duty0", 32'(log_q[0].dv), 32'd16);
            chk("f1_duty1", 32'(log_q[1].dv), 32'd32);
            chk("f1_duty2", 32'(log_q[2].dv), 32'd40);
            chk("f1_chan",  32'(log_q[2].ld), 32'd4);
        end
        chk("f1_idle", 32'(busy), 32'd0);

        log_q.delete();
        step(3'b100, 0, 0, 0);
        repeat (20) step(3'b000, 0, 0, 0);
        chk("f2_nloads", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("f2_duty0", 32'(log_q[0].dv), 32'd24);
            chk("f2_duty1", 32'(log_q[1].dv), 32'd8);
            chk("f2_duty2", 32'(log_q[2].dv), 32'd0);
        end
        chk("f2_idle", 32'(busy), 32'd0);
`endif

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
